// File: rtl/etc_tile_accum_pkg.sv
// Shared types for the extended-tensor-core tile path: reduction ops,
// accumulator FSM states and the 4x4 tile type.
package etc_pkg;

    localparam int ETC_W = 16;

    typedef enum logic [1:0] {
        RED_ADD = 2'b00,
        RED_MIN = 2'b01,
        RED_MAX = 2'b10,
        RED_OR  = 2'b11
    } etc_red_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        HOLD = 2'b10
    } etc_acc_state_e;

    // Tile at the core's default element width.
    typedef logic [3:0][3:0][ETC_W-1:0] etc_tile_t;

endpackage

// File: rtl/etc_red_lane.sv
// Single-element semiring reducer: y = f(a, b) under op.
// With ETC_ACC_SAT_EN defined, add saturates and clamp flags the clip.
module etc_red_lane
    import etc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  etc_red_op_e  op,
`ifdef ETC_ACC_SAT_EN
    output logic         clamp,
`endif
    output logic [W-1:0] y
);

`ifdef ETC_ACC_SAT_EN
    logic [W:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};
`endif

    // Element-wise reduction, all compares unsigned.
    always_comb begin
        y = a;
`ifdef ETC_ACC_SAT_EN
        clamp = 1'b0;
`endif
        case (op)
`ifdef ETC_ACC_SAT_EN
            RED_ADD: begin
                y     = sum[W] ? {W{1'b1}} : sum[W-1:0];
                clamp = sum[W];
            end
`else
            RED_ADD: y = a + b;
`endif
            RED_MIN: y = (b < a) ? b : a;
            RED_MAX: y = (b > a) ? b : a;
            RED_OR:  y = a | b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/etc_tile_accum.sv
// Tile accumulator: reduces num_k 4x4 partial tiles element-wise and
// presents the result on a valid/ready output.
// Optional: ETC_ACC_SAT_EN turns add into saturating add and adds sat_flag.
module etc_tile_accum
    import etc_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         num_k,
    input  logic [1:0]            op,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][3:0][W-1:0] in_tile,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef ETC_ACC_SAT_EN
    output logic                  sat_flag,
`endif
    output logic [3:0][3:0][W-1:0] out_tile,
    output logic                  busy
);

    etc_acc_state_e state, state_nx;
    etc_red_op_e    op_q;
    logic [KW-1:0]  nk_q;
    logic [KW-1:0]  count;
    logic [KW:0]    count_inc;
    logic           accept;
    logic           last;
    logic [3:0][3:0][W-1:0] red;
`ifdef ETC_ACC_SAT_EN
    logic [3:0][3:0] clamp;
`endif

    assign accept    = in_valid & in_ready;
    // Extra bit keeps count+1 from wrapping when num_k is at its maximum.
    assign count_inc = {1'b0, count} + {{KW{1'b0}}, 1'b1};
    assign last      = accept && (count_inc == {1'b0, nk_q});

    // One reducer per tile element; out_tile doubles as the accumulator.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            etc_red_lane #(.W(W)) u_lane (
                .a     (out_tile[gi][gj]),
                .b     (in_tile[gi][gj]),
                .op    (op_q),
`ifdef ETC_ACC_SAT_EN
                .clamp (clamp[gi][gj]),
`endif
                .y     (red[gi][gj])
            );
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nx = ACC;
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latched config, tile count and accumulator datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= RED_ADD;
            nk_q     <= {{(KW-1){1'b0}}, 1'b1};
            count    <= '0;
            out_tile <= '0;
`ifdef ETC_ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                op_q     <= etc_red_op_e'(op);
                nk_q     <= (num_k == '0) ? {{(KW-1){1'b0}}, 1'b1} : num_k;
                count    <= '0;
`ifdef ETC_ACC_SAT_EN
                sat_flag <= 1'b0;
`endif
            end
            if (accept) begin
                // First tile loads directly, so no identity element is needed.
                out_tile <= (count == '0) ? in_tile : red;
                count    <= count_inc[KW-1:0];
`ifdef ETC_ACC_SAT_EN
                if (count != '0 && |clamp) sat_flag <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_etc_tile_accum.sv
// Randomized and directed bench for etc_tile_accum against a queue-based
// reduction model. Honors ETC_ACC_SAT_EN when defined.
module tb_etc_tile_accum;

    typedef logic [3:0][3:0][15:0] tile_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_k = '0;
    logic [1:0] op = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    tile_t      in_tile = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    tile_t      out_tile;
    logic       busy;
`ifdef ETC_ACC_SAT_EN
    logic       sat_flag;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    etc_tile_accum #(.W(16), .KW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_k     (num_k),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tile   (in_tile),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ETC_ACC_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .out_tile  (out_tile),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting tiles, 2 result presented
    int    m_phase = 0;
    int    m_op = 0;
    int    m_nk = 1;
    tile_t m_q[$];
    tile_t m_res = '0;
    bit    m_sat = 0;

    function automatic tile_t reduce(input int rop, input tile_t q[$], output bit sat);
        tile_t r;
        int unsigned acc, b, s;
        sat = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = q[0][i][j];
                for (int k = 1; k < q.size(); k++) begin
                    b = q[k][i][j];
                    case (rop)
                        0: begin
                            s = acc + b;
`ifdef ETC_ACC_SAT_EN
                            if (s > 65535) begin s = 65535; sat = 1; end
`endif
                            acc = s % 65536;
                        end
                        1: acc = (b < acc) ? b : acc;
                        2: acc = (b > acc) ? b : acc;
                        default: acc = acc | b;
                    endcase
                end
                r[i][j] = acc[15:0];
            end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_op = op;
                    m_nk = (num_k == 0) ? 1 : num_k;
                    m_q.delete();
                    m_phase = 1;
                end
                1: if (in_valid) begin
                    m_q.push_back(in_tile);
                    if (m_q.size() == m_nk) begin
                        m_res = reduce(m_op, m_q, m_sat);
                        m_phase = 2;
                        done_cnt++;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, m_phase == 1);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2) begin
                chk("out_tile", out_tile, m_res);
`ifdef ETC_ACC_SAT_EN
                chk("sat_flag", sat_flag, m_sat);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [7:0] n);
        start = 1'b1; op = o; num_k = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(input tile_t t);
        in_valid = 1'b1; in_tile = t;
        cyc();
        in_valid = 1'b0;
    endtask

    function automatic tile_t fill(input logic [15:0] v);
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) t[i][j] = v;
        return t;
    endfunction

    function automatic tile_t rnd_tile();
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) t[i][j] = 16'($urandom);
        return t;
    endfunction

    initial begin
        tile_t ta, tb;
        int guard;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_tile", out_tile, 256'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Add 5+7+9, back-to-back, one-cycle latency
        out_ready = 1'b1;
        do_start(2'b00, 8'd3);
        feed(fill(16'd5)); feed(fill(16'd7)); feed(fill(16'd9));
        chk("add_latency_valid", out_valid, 1'b1);
        chk("add_elem00", out_tile[0][0], 16'd21);
        chk("add_elem33", out_tile[3][3], 16'd21);
        cyc();
        chk("add_back_idle", busy, 1'b0);

        // Min / max on element [2][1]
        ta = rnd_tile(); tb = rnd_tile();
        ta[2][1] = 16'h0030; tb[2][1] = 16'h0010;
        do_start(2'b01, 8'd2);
        feed(ta); feed(tb);
        chk("min_elem21", out_tile[2][1], 16'h0010);
        cyc();
        ta = rnd_tile(); tb = rnd_tile();
        ta[2][1] = 16'hFFFF; tb[2][1] = 16'h0001;
        do_start(2'b10, 8'd2);
        feed(ta); feed(tb);
        chk("max_elem21", out_tile[2][1], 16'hFFFF);
        cyc();

        // Wrap vs saturate
        do_start(2'b00, 8'd2);
        feed(fill(16'hFFF0)); feed(fill(16'h0020));
`ifdef ETC_ACC_SAT_EN
        chk("sat_elem", out_tile[1][2], 16'hFFFF);
        chk("sat_flag_set", sat_flag, 1'b1);
`else
        chk("wrap_elem", out_tile[1][2], 16'h0010);
`endif
        cyc();
        do_start(2'b00, 8'd2);
        feed(fill(16'h0100)); feed(fill(16'h0200));
        chk("add_small", out_tile[0][1], 16'h0300);
`ifdef ETC_ACC_SAT_EN
        chk("sat_flag_clear", sat_flag, 1'b0);
`endif
        cyc();

        // num_k=0 with OR, backpressure, start during HOLD ignored
        out_ready = 1'b0;
        do_start(2'b11, 8'd0);
        feed(fill(16'h00AA));
        chk("nk0_valid", out_valid, 1'b1);
        chk("nk0_elem", out_tile[2][2], 16'h00AA);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2); in_valid = 1'b1; in_tile = rnd_tile();
            cyc();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_elem", out_tile[1][3], 16'h00AA);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bp_released", busy, 1'b0);

        // Reset mid-ACC
        do_start(2'b00, 8'd4);
        feed(fill(16'd100)); feed(fill(16'd50));
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_tile", out_tile, 256'd0);
        cyc();
        rst = 1'b0;
        cyc();
        do_start(2'b00, 8'd1);
        feed(fill(16'd3));
        chk("post_rst_elem", out_tile[3][0], 16'd3);
        cyc();

        // Start coincident with the output handshake
        out_ready = 1'b0;
        do_start(2'b00, 8'd1);
        feed(fill(16'd9));
        out_ready = 1'b1; start = 1'b1;
        cyc();
        chk("hs_start_ignored", busy, 1'b0);
        cyc();
        chk("hs_start_next", busy, 1'b1);
        start = 1'b0;
        feed(fill(16'd4));
        cyc();

        // Randomized traffic; the compare process does the checking.
        guard = 0;
        done_cnt = 0;
        while (done_cnt < 40 && guard < 4000) begin
            start     = ($urandom_range(0, 3) == 0);
            op        = 2'($urandom);
            num_k     = 8'($urandom_range(0, 4));
            in_valid  = ($urandom_range(0, 9) < 6);
            in_tile   = ($urandom_range(0, 1) == 0) ? rnd_tile() : fill(16'($urandom_range(65000, 65535)));
            out_ready = ($urandom_range(0, 1) == 0);
            cyc();
            guard++;
        end
        total++;
        if (done_cnt < 40) begin
            bad++;
            $display("FAIL random_progress: got %0d reductions expected 40", done_cnt);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/etc_tile_accum.md
Name: etc_tile_accum

Overview:
- Downstream stage of the 4x4 extended-tensor-core tile unit.
- Consumes a sequence of 4x4 W-bit partial-result tiles, one per K-step, and reduces them element-wise under a selectable semiring reduction: add, min, max or bitwise-or.
- After num_k tiles it presents the finished 4x4 tile on a valid/ready output.
- Sits between the core's registered output and the result write-back path.

Parameters:
- W, 16, element width in bits; matches the core's W.
- KW, 8, width of the K-tile count field.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset: asynchronous, active-high.
- start  input  1  begin a new reduction; sampled only in IDLE.
- num_k  input  KW  number of tiles to reduce; latched with start; 0 is treated as 1.
- op  input  2  reduction select, latched with start: 00 add, 01 min, 10 max, 11 or.
- in_valid  input  1  in_tile carries a valid partial tile.
- in_ready  output  1  block accepts in_tile this cycle.
- in_tile  input  [3:0][3:0][W-1:0]  partial tile from the core.
- out_valid  output  1  out_tile holds a finished result.
- out_ready  input  1  consumer accepts out_tile.
- out_tile  output  [3:0][3:0][W-1:0]  reduced tile, registered.
- busy  output  1  high in ACC or HOLD.

Behaviour:
Reset (asynchronous, takes effect immediately):
- State IDLE; in_ready=0, out_valid=0, busy=0.
- out_tile=0, tile count=0, latched op=00, latched num_k=1.

States:
- IDLE:
  - in_ready=0.
  - start=1 latches op and num_k (0 becomes 1), clears count, goes to ACC next cycle.
  - in_valid is ignored.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid&in_ready accepts one tile.
  - First accepted tile (count=0) loads the accumulator directly; no identity element is used.
  - Each later tile combines element-wise: acc[i][j] = f(acc[i][j], in_tile[i][j]).
  - Count increments per accepted tile. When the accepted tile makes count==num_k, the result is written and the state is HOLD next cycle.
  - start is ignored.
- HOLD:
  - out_valid=1, in_ready=0, out_tile stable.
  - out_valid&out_ready returns to IDLE next cycle.
  - A start in the same cycle as that handshake is ignored; start is accepted from the following IDLE cycle.

Reduction f, unsigned, per element:
- add: modulo 2^W wrap, no carry out.
- min / max: unsigned compare.
- or: bitwise.

Timing and boundaries:
- The accumulator register is out_tile itself; its value is visible on out_tile in ACC but is valid only while out_valid=1.
- Latency: last accepted tile to out_valid=1 is 1 cycle. Back-to-back tiles accepted every cycle; in_valid gaps are tolerated indefinitely.
- Count cannot wrap: max num_k is 2^KW-1, and count compares equal before overflow.
- Reset mid-ACC or mid-HOLD discards the partial result and returns to reset values immediately.

Optional Feature:
- Macro ETC_ACC_SAT_EN.
- Defined: op 00 is a saturating unsigned add; the result clamps to 2^W-1 when the true sum exceeds it. A sticky output sat_flag (1 bit, reset 0) is added. It is cleared on start acceptance and set whenever any element clamps during the current reduction. It is valid with out_valid.
- Undefined: op 00 wraps modulo 2^W and the sat_flag port does not exist.

Decomposition:
- Shared package etc_pkg:
  - enum etc_red_op_e {RED_ADD=2'b00, RED_MIN=2'b01, RED_MAX=2'b10, RED_OR=2'b11}.
  - State enum etc_acc_state_e {IDLE, ACC, HOLD}.
  - Tile typedef parameterised by W, shared with the core.
- One sub-module etc_red_lane:
  - Combinational single-element reducer (a, b, op) -> y, plus a clamp bit under ETC_ACC_SAT_EN.
  - Instantiated 16 times via generate.

Test Plan:
- Add, num_k=3: start with op=00, num_k=3. Feed tiles all elements 5, 7, 9 back-to-back. Expect out_valid exactly 1 cycle after the third accept, all elements 21. With out_ready=1, return to IDLE next cycle.
- Min/max, num_k=2, element [2][1]: min of tiles 0x0030 and 0x0010 -> 0x0010; max of 0xFFFF and 0x0001 -> 0xFFFF. Other elements are checked per the same rule.
- Wrap vs saturate, add, num_k=2, elements 0xFFF0 and 0x0020: without macro -> 0x0010. With ETC_ACC_SAT_EN -> 0xFFFF and sat_flag=1. The next reduction has sat_flag=0.
- num_k=0 and backpressure: with num_k=0, a single tile (all elements 0x00AA) completes, with op=11 -> 0x00AA. Hold out_ready=0 for 5 cycles: out_valid stays 1, in_ready stays 0, out_tile unchanged. A start pulse during HOLD is ignored.
- Reset mid-ACC: num_k=4; after 2 tiles assert rst. Outputs go to reset values immediately. A new start with num_k=1 and tile value 3 gives result 3, with no residue from the prior reduction.
- Handshake corner: assert start in the same cycle as the out_valid&out_ready handshake. Expect IDLE next cycle with no new reduction. Start in the following cycle is accepted; busy goes to 1.
